req_skid_buf: RTL and testbench

Two-entry valid/ready skid buffer that sits directly upstream of the cache's enable-gated pipeline registers. It accepts request words from the core side and presents them to the cache stage one word per cycle. It decouples the backpressure path so that `in_ready` is a pure register output with no combinational path from `out_ready`. It sustains full throughput: one word per cycle in steady state.

---
 rtl/req_skid_buf.sv | 112 +++++++++++
 tb/tb_req_skid_buf.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/req_skid_buf.sv
// req_skid_buf
// Two-entry valid/ready skid buffer placed in front of the cache's
// enable-gated pipeline registers. Words accepted from the core side are
// presented to the cache stage one per cycle, in acceptance order.
// The backpressure path is broken by a register: in_ready is a flop output
// with no combinational dependence on out_ready. One word per cycle is
// sustained while the consumer keeps out_ready high.
//
// Ports:
//   clk        sole clock, rising edge
//   reset      synchronous, active-high; clears occupancy and both data words
//   in_valid   producer has a word on in_data
//   in_ready   buffer can accept this cycle (registered)
//   in_data    producer word, DATA_W bits
//   out_valid  out_data holds a valid word (registered)
//   out_ready  consumer takes the word this cycle
//   out_data   word presented to the cache stage (main register)
//   level      occupancy 0/1/2 (registered, equals the state encoding)

module req_skid_buf #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        level
);

   // State encoding doubles as the occupancy count driven on level.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] mainData_q, mainData_d;
   logic [DATA_W-1:0] skidData_q, skidData_d;
   logic              inReady_q;
   logic              outValid_q;
   logic              inFire;
   logic              outFire;

   assign inFire  = in_valid && inReady_q;
   assign outFire = outValid_q && out_ready;

   // Next-state and data steering. The main register always holds the
   // oldest word; the skid register only fills when a word arrives while
   // the consumer is stalled, and it is emptied into main on the next drain.
   always_comb begin
      state_d    = state_q;
      mainData_d = mainData_q;
      skidData_d = skidData_q;
      case (state_q)
         EMPTY: begin
            if (inFire) begin
               mainData_d = in_data;
               state_d    = ONE;
            end
         end
         ONE: begin
            if (inFire && outFire) begin
               mainData_d = in_data;
            end else if (inFire) begin
               skidData_d = in_data;
               state_d    = FULL;
            end else if (outFire) begin
               // main keeps its stale value; out_valid masks it
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (outFire) begin
               mainData_d = skidData_q;
               state_d    = ONE;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
   end

   // State and data registers. in_ready and out_valid are recomputed from
   // the next state so both handshake outputs come straight from flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= EMPTY;
         mainData_q <= '0;
         skidData_q <= '0;
         inReady_q  <= 1'b1;
         outValid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         mainData_q <= mainData_d;
         skidData_q <= skidData_d;
         inReady_q  <= (state_d != FULL);
         outValid_q <= (state_d != EMPTY);
      end
   end

   assign in_ready  = inReady_q;
   assign out_valid = outValid_q;
   assign out_data  = mainData_q;
   assign level     = state_q;

endmodule

// File: tb/tb_req_skid_buf.sv
// tb_req_skid_buf
// Directed bench for req_skid_buf. Every accepted word is pushed onto a
// scoreboard queue; every drain pops the front and compares it with
// out_data. After each clock the occupancy-related outputs are compared
// against the queue depth and out_data against the expected main word.

module tb_req_skid_buf;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [1:0]  level;

   logic [31:0] sbQueue[$];
   logic [31:0] expMain;
   int          checks;
   int          errors;

   req_skid_buf #(.DATA_W(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .level     (level)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts, asserts and reports.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Compare all outputs against the scoreboard after a clock edge.
   task automatic checkState(input string tag);
      int depth;
      depth = sbQueue.size();
      checkOutput({tag, "_level"}, {30'd0, level}, depth[31:0]);
      checkOutput({tag, "_out_valid"}, {31'd0, out_valid}, {31'd0, (depth != 0)});
      checkOutput({tag, "_in_ready"}, {31'd0, in_ready}, {31'd0, (depth < 2)});
      checkOutput({tag, "_out_data"}, out_data, expMain);
   endtask

   // Drive one cycle of inputs, update the scoreboard from the handshakes
   // seen just before the edge, then sample outputs 1 ns after the edge.
   task automatic applyStimulus(input string tag, input logic rst, input logic vld,
                                input logic [31:0] dat, input logic rdy);
      logic [31:0] popped;
      reset     = rst;
      in_valid  = vld;
      in_data   = dat;
      out_ready = rdy;
      #1;
      if (!rst) begin
         if (out_valid && out_ready) begin
            if (sbQueue.size() == 0) begin
               checkOutput({tag, "_drain_with_empty_sb"}, {31'd0, out_valid}, 32'd0);
            end else begin
               popped = sbQueue.pop_front();
               checkOutput({tag, "_drain_order"}, out_data, popped);
            end
         end
         if (in_valid && in_ready) begin
            sbQueue.push_back(in_data);
         end
      end
      @(posedge clk);
      #1;
      if (rst) begin
         sbQueue.delete();
         expMain = 32'd0;
      end else if (sbQueue.size() != 0) begin
         expMain = sbQueue[0];
      end
      checkState(tag);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      expMain   = 32'd0;
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = 32'd0;
      out_ready = 1'b0;
      @(negedge clk);

      // Reset held with a word offered: nothing may be captured.
      $display("[TB] reset with in_valid high");
      for (int i = 0; i < 3; i++) applyStimulus("reset_hold", 1'b1, 1'b1, 32'hAAAA_AAAA, 1'b1);
      applyStimulus("post_reset_first", 1'b0, 1'b1, 32'h0000_BEEF, 1'b0);
      checkOutput("first_word_after_reset", out_data, 32'h0000_BEEF);
      applyStimulus("post_reset_drain", 1'b0, 1'b0, 32'h0, 1'b1);

      // Single word held under a 5-cycle stall, then drained.
      $display("[TB] single word with stall");
      applyStimulus("single_push", 1'b0, 1'b1, 32'h1234_5678, 1'b0);
      checkOutput("single_visible", out_data, 32'h1234_5678);
      for (int i = 0; i < 5; i++) applyStimulus("single_stall", 1'b0, 1'b0, 32'hDEAD_0000, 1'b0);
      checkOutput("single_held", out_data, 32'h1234_5678);
      applyStimulus("single_drain", 1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("single_level_zero", {30'd0, level}, 32'd0);

      // Full-rate streaming.
      $display("[TB] streaming 0x1..0x10");
      for (int i = 1; i <= 16; i++) applyStimulus("stream", 1'b0, 1'b1, i, 1'b1);
      applyStimulus("stream_tail", 1'b0, 1'b0, 32'h0, 1'b1);

      // Skid fill: consumer stalls while the producer keeps offering.
      $display("[TB] skid fill");
      applyStimulus("skid_a", 1'b0, 1'b1, 32'hA, 1'b0);
      applyStimulus("skid_b", 1'b0, 1'b1, 32'hB, 1'b0);
      checkOutput("skid_full_level", {30'd0, level}, 32'd2);
      checkOutput("skid_full_in_ready", {31'd0, in_ready}, 32'd0);
      applyStimulus("skid_c_blocked", 1'b0, 1'b1, 32'hC, 1'b0);
      checkOutput("skid_a_held", out_data, 32'hA);
      applyStimulus("skid_drain_a", 1'b0, 1'b1, 32'hC, 1'b1);
      checkOutput("skid_b_promoted", out_data, 32'hB);
      applyStimulus("skid_drain_b", 1'b0, 1'b1, 32'hC, 1'b1);
      checkOutput("skid_c_visible", out_data, 32'hC);
      applyStimulus("skid_drain_c", 1'b0, 1'b0, 32'h0, 1'b1);

      // Accept and drain on the same edge while in ONE.
      $display("[TB] simultaneous accept and drain");
      applyStimulus("simul_prime", 1'b0, 1'b1, 32'h100, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         applyStimulus("simul", 1'b0, 1'b1, 32'h100 + i, 1'b1);
         checkOutput("simul_out_data", out_data, 32'h100 + i);
      end
      applyStimulus("simul_tail", 1'b0, 1'b0, 32'h0, 1'b1);

      // Reset while FULL discards both buffered words.
      $display("[TB] reset mid-operation");
      applyStimulus("mid_push_55", 1'b0, 1'b1, 32'h55, 1'b0);
      applyStimulus("mid_push_66", 1'b0, 1'b1, 32'h66, 1'b0);
      checkOutput("mid_full_level", {30'd0, level}, 32'd2);
      applyStimulus("mid_reset", 1'b1, 1'b1, 32'h77, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus("mid_after", 1'b0, 1'b0, 32'h0, 1'b1);
      applyStimulus("mid_new_word", 1'b0, 1'b1, 32'h88, 1'b1);
      checkOutput("mid_new_word_data", out_data, 32'h88);
      applyStimulus("mid_new_drain", 1'b0, 1'b0, 32'h0, 1'b1);

      checkOutput("sb_empty_at_end", sbQueue.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
